voice_phase_scheduler: RTL

- Time-shares one external 5-bit ripple adder (a, b, c_in -> sum, c_out) across NUM_VOICES oscillator voices, so each voice gets a wide phase accumulator.
- On each sample tick, adds each voice's increment to its phase one 5-bit chunk per cycle, carrying between chunks.
- Sits between the note/config logic and the wavetable lookup in the synth voice path.

---
 rtl/voice_phase_scheduler.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/voice_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : voice_phase_scheduler
// Brief    : Time-shares one external 5-bit adder across NUM_VOICES phase
//            accumulators, one chunk per cycle, on every sample tick.
//            Optional hard sync is enabled by defining VOICE_HARD_SYNC_EN.
// Revision : 1.0 - initial release
// ============================================================================
module voice_phase_scheduler #(
    parameter int NUM_VOICES = 4,
    parameter int CHUNKS     = 4,
    parameter int VW         = 2,
    localparam int PW        = 5 * CHUNKS
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tick,
    input  logic          cfg_we,
    input  logic [VW-1:0] cfg_voice,
    input  logic [PW-1:0] cfg_inc,
`ifdef VOICE_HARD_SYNC_EN
    input  logic          sync_we,
    input  logic [VW-1:0] sync_voice,
`endif
    output logic [4:0]    add_a,
    output logic [4:0]    add_b,
    output logic          add_cin,
    input  logic [4:0]    add_sum,
    input  logic          add_cout,
    output logic          phase_valid,
    output logic [VW-1:0] phase_voice,
    output logic [PW-1:0] phase_data,
    output logic          busy,
    output logic          done,
    output logic          overrun
);

    localparam int KW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    typedef logic [CHUNKS-1:0][4:0] word_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next;

    word_t         r_phase    [NUM_VOICES];
    word_t         r_inc_pend [NUM_VOICES];
    word_t         r_inc_act  [NUM_VOICES];

    logic [VW-1:0] r_v;
    logic [KW-1:0] r_k;
    logic          r_carry;

    logic          r_phase_valid;
    logic [VW-1:0] r_phase_voice;
    logic [PW-1:0] r_phase_data;
    logic          r_overrun;

    logic          w_last_chunk;
    logic          w_last_voice;
    word_t         w_new_phase;

`ifdef VOICE_HARD_SYNC_EN
    logic [NUM_VOICES-1:0] r_sync;
`endif

    assign w_last_chunk = (r_k == KW'(CHUNKS - 1));
    assign w_last_voice = (r_v == VW'(NUM_VOICES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (tick) w_next = S_LOAD;
            S_LOAD:  w_next = S_RUN;
            S_RUN:   if (w_last_chunk && w_last_voice) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Adder operands come straight from registers; the sum is spliced back
    // into the current voice's phase word to form the write-back value.
    always_comb begin
        add_a   = 5'd0;
        add_b   = 5'd0;
        add_cin = 1'b0;
        if (r_state == S_RUN) begin
            add_a   = r_phase[r_v][r_k];
            add_b   = r_inc_act[r_v][r_k];
            add_cin = (r_k == '0) ? 1'b0 : r_carry;
        end
        w_new_phase      = r_phase[r_v];
        w_new_phase[r_k] = add_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_phase[i]    <= '0;
                r_inc_pend[i] <= '0;
                r_inc_act[i]  <= '0;
            end
            r_v           <= '0;
            r_k           <= '0;
            r_carry       <= 1'b0;
            r_phase_valid <= 1'b0;
            r_phase_voice <= '0;
            r_phase_data  <= '0;
            r_overrun     <= 1'b0;
`ifdef VOICE_HARD_SYNC_EN
            r_sync        <= '0;
`endif
        end else begin
            r_phase_valid <= 1'b0;

            if (tick && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end

            if (cfg_we) begin
                r_inc_pend[cfg_voice] <= cfg_inc;
            end

            case (r_state)
                S_LOAD: begin
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        r_inc_act[i] <= r_inc_pend[i];
                    end
                    if (cfg_we) begin
                        r_inc_act[cfg_voice] <= cfg_inc;
                    end
                    r_v     <= '0;
                    r_k     <= '0;
                    r_carry <= 1'b0;
`ifdef VOICE_HARD_SYNC_EN
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (r_sync[i]) begin
                            r_phase[i] <= '0;
                            r_sync[i]  <= 1'b0;
                        end
                    end
`endif
                end
                S_RUN: begin
                    r_phase[r_v] <= w_new_phase;
                    r_carry      <= add_cout;
                    if (w_last_chunk) begin
                        r_k           <= '0;
                        r_v           <= r_v + 1'b1;
                        r_phase_valid <= 1'b1;
                        r_phase_voice <= r_v;
                        r_phase_data  <= w_new_phase;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                default: ;
            endcase

`ifdef VOICE_HARD_SYNC_EN
            // Placed after the LOAD clear so a request in that cycle survives
            // for the following frame.
            if (sync_we) begin
                r_sync[sync_voice] <= 1'b1;
            end
`endif
        end
    end

    assign phase_valid = r_phase_valid;
    assign phase_voice = r_phase_voice;
    assign phase_data  = r_phase_data;
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign overrun     = r_overrun;

endmodule
`default_nettype wire
